alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Integer execute stage directly downstream of the reservation station. Takes one ready
//   operation per cycle (opcode, ROB tag, both operand values) and computes the result.
//   Broadcasts {valid, rob, value} on a 23-bit forward bus. That bus drives one forwardX
//   input of every reservation station and the ROB write port. Single-cycle ops have
//   latency 1; MUL runs an iterative multi-cycle path.
// PARAMETERS
//   DATA_W   16  operand/result width
//   ROB_W    6   ROB tag width
//   MUL_DIG  4   multiplier bits retired per iteration (DATA_W/MUL_DIG iterations)
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       reset, asynchronous assert, active low
//   flush        in   1       mispredict kill of all in-flight work
//   issueValid   in   1       issue slot holds a ready operation
//   issueOpcode  in   4       operation code (ooo_pkg::op_e)
//   issueRob     in   ROB_W   destination ROB tag
//   issueA       in   DATA_W  operand A value
//   issueB       in   DATA_W  operand B value
//   issueReady   out  1       unit can accept this cycle; accept = issueValid & issueReady
//   fwdOut       out  23      {valid, rob[5:0], value[15:0]} result broadcast
//   busy         out  1       MUL in progress
// BEHAVIOUR
//   Reset: fwdOut=0, issueReady=1, busy=0, FSM=IDLE, all pipeline regs cleared.
//   Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 SRA (amount=B[3:0]),
//     8 SLT signed, 9 SLTU (result 0/1), 10 MUL (low DATA_W bits), 11 PASSB,
//     12-15 illegal -> value 0, still broadcast so the ROB entry retires.
//   All arithmetic is modulo 2^DATA_W; no carry or overflow output.
//   Single-cycle op accepted at edge E: fwdOut={1,rob,result} for exactly the cycle after E.
//   fwdOut.valid=0 in every cycle with no completion. Broadcast is unconditional (no stall).
//   FSM: IDLE --accept MUL--> MUL (DATA_W/MUL_DIG iterations, first at accept edge)
//     -> IDLE on the last iteration, registering the broadcast.
//   Default MUL timing: accept at E0; result on fwdOut after E3.
//   issueReady=0 and busy=1 from after E0 until the result cycle. issueReady returns to 1
//     in the broadcast cycle, so back-to-back issue is allowed.
//   Only one completion source per cycle by construction; no output arbitration needed.
//   flush: synchronous. At the flush edge the FSM goes to IDLE and any registered result
//     is dropped (fwdOut.valid=0 next cycle). An issue in the same cycle is dropped.
//     issueReady=1 the next cycle.
//   rst_n asserted mid-MUL aborts immediately; no stale broadcast after release.
// CONFIGURATION
//   ALU_MUL_EN defined: iterative multiplier present, MUL follows the FSM above.
//   ALU_MUL_EN undefined: no multiplier or FSM; opcode 10 is illegal (value 0, latency 1);
//     busy tied 0; issueReady tied 1 outside reset.
// STRUCTURE
//   ooo_pkg: op_e enum, DATA_W/ROB_W constants, fwd_t packed struct {valid, rob, value},
//     FWD_W=23. Shared with the reservation station and ROB.
//   Sub-module mul_iter: radix-2^MUL_DIG shift-add multiplier.
//     Ports: start/a/b in, done/product out, abort input tied to flush.
//     Instantiated only under ALU_MUL_EN.
// TESTING
//   ADD A=0x0003 B=0x0004 rob=5 -> next cycle fwdOut={1,5,0x0007}, then valid=0.
//   SUB A=0x0000 B=0x0001 rob=2 -> 0xFFFF. SRA A=0x8000 B=4 -> 0xF800.
//   SLT A=0xFFFF B=0x0001 -> 1. SLTU with the same operands -> 0.
//   MUL A=0x0012 B=0x0034 rob=9 (ALU_MUL_EN) -> issueReady low 3 cycles,
//     then fwdOut={1,9,0x03A8}. ADD issued in that same cycle is broadcast the next cycle.
//   MUL accepted, flush at the 2nd cycle -> no MUL broadcast; issueReady=1 next cycle.
//   rst_n low mid-MUL -> outputs reset values; after release no broadcast until a new issue.
//   ALU_MUL_EN undefined, MUL 0x0012*0x0034 -> next cycle fwdOut={1,rob,0x0000}; busy never 1.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: opcodes, forward-bus layout, and the single-cycle ALU function.
package ooo_pkg;
  localparam int DATA_W  = 16;
  localparam int ROB_W   = 6;
  localparam int MUL_DIG = 4;
  localparam int FWD_W   = 1 + ROB_W + DATA_W;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SHL   = 4'd5,
    OP_SHR   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_MUL   = 4'd10,
    OP_PASSB = 4'd11
  } op_e;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] value;
  } fwd_t;

  // MUL and illegal codes fall to 0 here; the iterative path supplies MUL when present.
  function automatic logic [DATA_W-1:0] alu_op(input logic [3:0] op,
                                               input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [3:0] sh;
    sh = b[3:0];
    case (op)
      OP_ADD:   alu_op = a + b;
      OP_SUB:   alu_op = a - b;
      OP_AND:   alu_op = a & b;
      OP_OR:    alu_op = a | b;
      OP_XOR:   alu_op = a ^ b;
      OP_SHL:   alu_op = a << sh;
      OP_SHR:   alu_op = a >> sh;
      OP_SRA:   alu_op = $unsigned($signed(a) >>> sh);
      OP_SLT:   alu_op = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU:  alu_op = {{(DATA_W-1){1'b0}}, a < b};
      OP_PASSB: alu_op = b;
      default:  alu_op = '0;
    endcase
  endfunction
endpackage

// File: rtl/mul_iter.sv
// Radix-2^DIG shift-add multiplier; the first digit is retired on the start edge,
// product/done present the final accumulation combinationally on the last iteration.
module mul_iter
  import ooo_pkg::*;
#(
  parameter int W   = DATA_W,
  parameter int DIG = MUL_DIG
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);
  localparam int ITER = W / DIG;
  localparam int CW   = $clog2(ITER + 1);

  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d, a_q, a_d, b_q, b_d;
  logic [W-1:0]  op_a, op_b, base, acc_nxt;
  logic          adv;

  always_comb begin
    op_a    = start ? a : a_q;
    op_b    = start ? b : b_q;
    base    = start ? '0 : acc_q;
    acc_nxt = base + op_a * W'(op_b[DIG-1:0]);
    adv     = start | run_q;
    acc_d   = adv ? acc_nxt : acc_q;
    a_d     = adv ? (op_a << DIG) : a_q;
    b_d     = adv ? (op_b >> DIG) : b_q;
    done    = run_q && (cnt_q == CW'(ITER - 1));
    product = acc_nxt;
    run_d   = run_q;
    cnt_d   = cnt_q;
    if (abort) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      run_d = 1'b1;
      cnt_d = CW'(1);
    end else if (done) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (run_q) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute stage: single-cycle ALU plus optional iterative MUL (ALU_MUL_EN),
// broadcasting {valid, rob, value} on the forward bus one cycle after completion.
module alu_exec_unit
  import ooo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issueValid,
  input  logic [3:0]        issueOpcode,
  input  logic [ROB_W-1:0]  issueRob,
  input  logic [DATA_W-1:0] issueA,
  input  logic [DATA_W-1:0] issueB,
  output logic              issueReady,
  output logic [FWD_W-1:0]  fwdOut,
  output logic              busy
);
  fwd_t fwd_q, fwd_d;
  logic accept;

  assign fwdOut = fwd_q;

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e            state_q, state_d;
  logic [ROB_W-1:0]  mul_rob_q, mul_rob_d;
  logic              mul_start, mul_done;
  logic [DATA_W-1:0] mul_prod;

  assign issueReady = (state_q == S_IDLE);
  assign busy       = (state_q == S_MUL);
  assign accept     = issueValid & issueReady & ~flush;
  assign mul_start  = accept && (issueOpcode == OP_MUL);

  mul_iter #(.W(DATA_W), .DIG(MUL_DIG)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .abort   (flush),
    .a       (issueA),
    .b       (issueB),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d   = state_q;
    mul_rob_d = mul_rob_q;
    fwd_d     = '0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mul_start) begin
            state_d   = S_MUL;
            mul_rob_d = issueRob;
          end else if (accept) begin
            fwd_d = '{valid: 1'b1, rob: issueRob, value: alu_op(issueOpcode, issueA, issueB)};
          end
        end
        S_MUL: begin
          if (mul_done) begin
            state_d = S_IDLE;
            fwd_d   = '{valid: 1'b1, rob: mul_rob_q, value: mul_prod};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mul_rob_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_rob_q <= mul_rob_d;
    end
  end
`else
  assign issueReady = 1'b1;
  assign busy       = 1'b0;
  assign accept     = issueValid & ~flush;

  always_comb begin
    fwd_d = '0;
    if (accept)
      fwd_d = '{valid: 1'b1, rob: issueRob, value: alu_op(issueOpcode, issueA, issueB)};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fwd_q <= '0;
    else        fwd_q <= fwd_d;
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit; covers ALU ops, flush, reset, and MUL timing
// for whichever build (ALU_MUL_EN defined or not) is compiled.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        issueValid = 1'b0;
  logic [3:0]  issueOpcode = '0;
  logic [5:0]  issueRob = '0;
  logic [15:0] issueA = '0;
  logic [15:0] issueB = '0;
  logic        issueReady;
  logic [22:0] fwdOut;
  logic        busy;
  logic        busy_seen = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  alu_exec_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .issueValid  (issueValid),
    .issueOpcode (issueOpcode),
    .issueRob    (issueRob),
    .issueA      (issueA),
    .issueB      (issueB),
    .issueReady  (issueReady),
    .fwdOut      (fwdOut),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (busy === 1'b1) busy_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [22:0] fw(input logic [5:0] r, input logic [15:0] v);
    return {1'b1, r, v};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [5:0] r,
                       input logic [15:0] a, input logic [15:0] b);
    issueValid  = 1'b1;
    issueOpcode = op;
    issueRob    = r;
    issueA      = a;
    issueB      = b;
  endtask

  task automatic idle();
    issueValid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [3:0] op, input logic [5:0] r,
                     input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    drive(op, r, a, b);
    step();
    chk(tag, fwdOut, fw(r, exp));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_fwd", fwdOut, 0);
    chk("rst_ready", issueReady, 1);
    chk("rst_busy", busy, 0);
    repeat (2) step();
    chk("rst_hold_fwd", fwdOut, 0);
    rst_n = 1'b1;

    // ADD then idle: exactly one broadcast cycle
    vec("add", 4'd0, 6'd5, 16'h0003, 16'h0004, 16'h0007);
    idle();
    step();
    chk("add_valid_drop", fwdOut[22], 0);

    // back-to-back single-cycle ops
    vec("sub",      4'd1,  6'd2,  16'h0000, 16'h0001, 16'hFFFF);
    vec("sra",      4'd7,  6'd1,  16'h8000, 16'h0004, 16'hF800);
    vec("slt",      4'd8,  6'd3,  16'hFFFF, 16'h0001, 16'h0001);
    vec("sltu",     4'd9,  6'd4,  16'hFFFF, 16'h0001, 16'h0000);
    vec("slt_pos",  4'd8,  6'd13, 16'h0001, 16'hFFFF, 16'h0000);
    vec("and",      4'd2,  6'd6,  16'hF0F0, 16'hFF00, 16'hF000);
    vec("or",       4'd3,  6'd7,  16'hF0F0, 16'hFF00, 16'hFFF0);
    vec("xor",      4'd4,  6'd8,  16'hF0F0, 16'hFF00, 16'h0FF0);
    vec("shl_mask", 4'd5,  6'd10, 16'h0001, 16'h001F, 16'h8000);
    vec("shr",      4'd6,  6'd11, 16'h8000, 16'h0004, 16'h0800);
    vec("passb",    4'd11, 6'd12, 16'h1234, 16'hABCD, 16'hABCD);
    vec("illegal",  4'd15, 6'd63, 16'h0005, 16'h0006, 16'h0000);
    vec("add_wrap", 4'd0,  6'd0,  16'hFFFF, 16'h0001, 16'h0000);
    idle();
    step();
    chk("idle_valid", fwdOut[22], 0);

    // flush drops a same-cycle issue
    drive(4'd0, 6'd20, 16'h0001, 16'h0001);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("flush_drop_issue", fwdOut[22], 0);
    chk("flush_ready", issueReady, 1);

`ifdef ALU_MUL_EN
    // MUL timing: ready low three cycles, result after the fourth edge
    drive(4'd10, 6'd9, 16'h0012, 16'h0034);
    step();
    idle();
    chk("mul_ready_c1", issueReady, 0);
    chk("mul_busy_c1", busy, 1);
    chk("mul_valid_c1", fwdOut[22], 0);
    step();
    chk("mul_ready_c2", issueReady, 0);
    step();
    chk("mul_ready_c3", issueReady, 0);
    chk("mul_valid_c3", fwdOut[22], 0);
    step();
    chk("mul_result", fwdOut, fw(6'd9, 16'h03A8));
    chk("mul_ready_back", issueReady, 1);
    chk("mul_busy_done", busy, 0);
    vec("add_after_mul", 4'd0, 6'd3, 16'h0001, 16'h0002, 16'h0003);
    idle();

    // flush in the second MUL cycle kills the result
    drive(4'd10, 6'd7, 16'h0003, 16'h0005);
    step();
    idle();
    step();
    flush = 1'b1;
    drive(4'd0, 6'd1, 16'h0001, 16'h0001);
    step();
    flush = 1'b0;
    idle();
    chk("mflush_valid", fwdOut[22], 0);
    chk("mflush_ready", issueReady, 1);
    chk("mflush_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mflush_no_bcast", fwdOut[22], 0);
    end
    drive(4'd10, 6'd4, 16'h0102, 16'h0203);
    step();
    idle();
    repeat (3) step();
    chk("mul_after_flush", fwdOut, fw(6'd4, 16'h0706));

    // reset mid-MUL aborts without a late broadcast
    drive(4'd10, 6'd8, 16'h0010, 16'h0010);
    step();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_fwd", fwdOut, 0);
    chk("mrst_ready", issueReady, 1);
    chk("mrst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mrst_no_bcast", fwdOut[22], 0);
    end
    chk("busy_seen", busy_seen, 1);
`else
    drive(4'd10, 6'd9, 16'h0012, 16'h0034);
    step();
    idle();
    chk("mul_illegal", fwdOut, fw(6'd9, 16'h0000));
    chk("mul_busy", busy, 0);
    chk("mul_ready", issueReady, 1);
    step();
    chk("mul_valid_drop", fwdOut[22], 0);
    chk("busy_seen", busy_seen, 0);
`endif

    vec("post_add", 4'd0, 6'd33, 16'h1000, 16'h0234, 16'h1234);
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
